// File: rtl/elevator_car_ctrl_if.sv
// Floor-call handshake between a call source and the elevator car controller.
// The source drives valid/floor; the controller returns ready and an error pulse.
interface elevator_car_ctrl_if #(
    parameter int FLOOR_W = 4
) ();
    logic               call_valid;
    logic [FLOOR_W-1:0] call_floor;
    logic               call_ready;
    logic               call_err;

    modport master (output call_valid, call_floor, input call_ready, call_err);
    modport slave  (input call_valid, call_floor, output call_ready, call_err);
endinterface

// File: rtl/elevator_car_ctrl.sv
// Single-car elevator controller: call handshake, timed floor stepping, door dwell,
// secure-floor code check with lockout, temperature maintenance flag, 7-segment floor display.
module elevator_car_ctrl #(
    parameter int NUM_FLOORS    = 16,
    parameter int FLOOR_W       = 4,
    parameter int SECURE_FLOOR  = 10,
    parameter int CODE_W        = 14,
    parameter int TEMP_W        = 8,
    parameter int TEMP_HI       = 85,
    parameter int TEMP_LO       = 55,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 8,
    parameter int MAX_FAILS     = 3
) (
    input  logic                clk,
    input  logic                reset,
    elevator_car_ctrl_if.slave  call,
    input  logic [CODE_W-1:0]   input_code,
    input  logic                update_enable,
    input  logic                check_permission,
    input  logic [TEMP_W-1:0]   temperature,
    output logic [FLOOR_W-1:0]  current_floor,
    output logic                move_up,
    output logic                move_down,
    output logic                door_open,
    output logic                secure,
    output logic                reject,
    output logic                lockout,
    output logic                maintenance_request,
    output logic [13:0]         floor_display
);
    localparam int TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam int FCW = $clog2(MAX_FAILS + 1);
    localparam logic [FLOOR_W:0]   NUM_F       = (FLOOR_W+1)'(NUM_FLOORS);
    localparam logic [FLOOR_W-1:0] SEC_F       = FLOOR_W'(SECURE_FLOOR);
    localparam logic [TCW-1:0]     TRAVEL_LAST = TCW'(TRAVEL_CYCLES - 1);
    localparam logic [DCW-1:0]     DOOR_LAST   = DCW'(DOOR_CYCLES - 1);
    localparam logic [FCW-1:0]     FAIL_LAST   = FCW'(MAX_FAILS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_DOOR} state_t;

    state_t             r_state, w_state_next;
    logic [FLOOR_W-1:0] r_target;
    logic [TCW-1:0]     r_travel_cnt;
    logic [DCW-1:0]     r_door_cnt;
    logic [CODE_W-1:0]  r_master_code;
    logic [FCW-1:0]     r_fail_cnt;
    logic               r_auth;

    logic               w_accept, w_bad_floor, w_is_secure, w_call_err, w_call_go;
    logic               w_travel_done, w_door_done;
    logic [FLOOR_W-1:0] w_next_floor;
    logic [3:0]         w_tens, w_ones;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0000110;
            4'd2:    seg7 = 7'b1011011;
            4'd3:    seg7 = 7'b1001111;
            4'd4:    seg7 = 7'b1100110;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1111101;
            4'd7:    seg7 = 7'b0000111;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1101111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        call.call_ready = (r_state == ST_IDLE) && !maintenance_request;
        w_accept        = call.call_valid && call.call_ready;
        w_bad_floor     = {1'b0, call.call_floor} >= NUM_F;
        w_is_secure     = call.call_floor == SEC_F;
        w_call_err      = w_accept && (w_bad_floor || (w_is_secure && !r_auth));
        w_call_go       = w_accept && !w_call_err;
        w_travel_done   = r_travel_cnt == TRAVEL_LAST;
        w_door_done     = r_door_cnt == DOOR_LAST;
        w_next_floor    = (r_target > current_floor) ? current_floor + 1'b1
                                                     : current_floor - 1'b1;
        w_tens          = 4'(int'(current_floor) / 10);
        w_ones          = 4'(int'(current_floor) % 10);
    end

    always_comb begin
        w_state_next = r_state;
        move_up      = 1'b0;
        move_down    = 1'b0;
        door_open    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_call_go)
                    w_state_next = (call.call_floor == current_floor) ? ST_DOOR : ST_MOVE;
            end
            ST_MOVE: begin
                move_up   = r_target > current_floor;
                move_down = r_target < current_floor;
                if (w_travel_done && (w_next_floor == r_target))
                    w_state_next = ST_DOOR;
            end
            ST_DOOR: begin
                door_open = 1'b1;
                if (w_door_done)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state             <= ST_IDLE;
            r_target            <= '0;
            r_travel_cnt        <= '0;
            r_door_cnt          <= '0;
            current_floor       <= '0;
            call.call_err       <= 1'b0;
            maintenance_request <= 1'b0;
            r_master_code       <= '0;
            r_fail_cnt          <= '0;
            r_auth              <= 1'b0;
            secure              <= 1'b0;
            reject              <= 1'b0;
            lockout             <= 1'b0;
            floor_display       <= {7'b0000000, 7'b0111111};
        end else begin
            r_state             <= w_state_next;
            call.call_err       <= w_call_err;
            maintenance_request <= (temperature >= TEMP_W'(TEMP_HI)) ||
                                   (temperature <= TEMP_W'(TEMP_LO));
            floor_display       <= {(w_tens == 4'd0) ? 7'b0000000 : seg7(w_tens), seg7(w_ones)};

            if (w_call_go)
                r_target <= call.call_floor;

            if (r_state == ST_MOVE) begin
                if (w_travel_done) begin
                    r_travel_cnt  <= '0;
                    current_floor <= w_next_floor;
                end else begin
                    r_travel_cnt <= r_travel_cnt + 1'b1;
                end
            end else begin
                r_travel_cnt <= '0;
            end

            if ((r_state == ST_DOOR) && !w_door_done)
                r_door_cnt <= r_door_cnt + 1'b1;
            else
                r_door_cnt <= '0;

            // Secure-floor use consumes the grant; a match in the same cycle re-grants below.
            if (w_call_go && w_is_secure)
                r_auth <= 1'b0;

            secure <= 1'b0;
            reject <= 1'b0;
            if (!lockout) begin
                if (update_enable) begin
                    r_master_code <= input_code;
                end else if (check_permission) begin
                    if (input_code == r_master_code) begin
                        secure     <= 1'b1;
                        r_fail_cnt <= '0;
                        r_auth     <= 1'b1;
                    end else begin
                        reject     <= 1'b1;
                        r_fail_cnt <= r_fail_cnt + 1'b1;
                        if (r_fail_cnt == FAIL_LAST) begin
                            lockout <= 1'b1;
                            r_auth  <= 1'b0;
                        end
                    end
                end
            end
        end
    end
endmodule
